// File: rtl/ce_divider_bank_pkg.sv
// ce_pkg: shared defaults and config record for the clock-enable divider bank.
// Fractional dithering is enabled at build time with the CE_FRAC_EN macro.
package ce_pkg;

    localparam int unsigned CE_NUM_CH    = 4;
    localparam int unsigned CE_DIV_W     = 8;
    localparam int unsigned CE_FRAC_W    = 8;
    localparam int unsigned CE_RESET_DIV = 15;

    typedef struct packed {
        logic [CE_DIV_W-1:0]  div;
        logic [CE_FRAC_W-1:0] frac;
    } ce_cfg_t;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int unsigned ce_sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ce_divider_bank_channel.sv
// ce_channel: one clock-enable divider with shadowed divider reload at period boundaries.
// With CE_FRAC_EN defined, a fractional accumulator stretches selected periods by one cycle.
module ce_channel
    import ce_pkg::*;
#(
`ifdef CE_FRAC_EN
    parameter int unsigned FRAC_W    = CE_FRAC_W,
`endif
    parameter int unsigned DIV_W     = CE_DIV_W,
    parameter int unsigned RESET_DIV = CE_RESET_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              hold,
    input  logic              sync,
    input  logic              wr,
`ifdef CE_FRAC_EN
    input  logic [FRAC_W-1:0] wr_frac,
`endif
    input  logic [DIV_W-1:0]  wr_div,
    output logic              ce_p,
    output logic              ce_n,
    output logic              sq
);

`ifdef CE_FRAC_EN
    localparam int unsigned CNT_W = DIV_W + 1;
`else
    localparam int unsigned CNT_W = DIV_W;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] w_shadow_nx;
    logic             r_en;
    logic [DIV_W:0]   w_cnt_x;
    logic [DIV_W:0]   w_half;
    logic [DIV_W:0]   w_end;
    logic             w_adv;
    logic             w_restart;
    logic             w_wrap;
    logic             w_load;

    // A write landing in the same cycle as a load is forwarded straight into the active divider.
    assign w_shadow_nx = wr ? wr_div : r_shadow;
    assign w_adv       = r_en & ~hold;
    assign w_restart   = sync | ~r_en;
    assign w_half      = ({1'b0, r_div} + (DIV_W+1)'(1)) >> 1;
    assign w_wrap      = w_adv & (w_cnt_x == w_end);
    assign w_load      = w_restart | w_wrap;

`ifdef CE_FRAC_EN
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W-1:0] r_frac;
    logic [FRAC_W-1:0] r_frac_sh;
    logic [FRAC_W-1:0] w_frac_sh_nx;
    logic [FRAC_W:0]   w_acc_sum;
    logic              r_xtra;

    // Carry at a wrap lengthens the following period: cnt runs on to div+1 before wrapping.
    assign w_frac_sh_nx = wr ? wr_frac : r_frac_sh;
    assign w_acc_sum    = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_cnt_x      = r_cnt;
    assign w_end        = {1'b0, r_div} + {{DIV_W{1'b0}}, r_xtra};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_frac    <= '0;
            r_frac_sh <= '0;
            r_xtra    <= 1'b0;
        end else begin
            r_frac_sh <= w_frac_sh_nx;
            if (w_load) r_frac <= w_frac_sh_nx;
            if (w_restart) begin
                r_xtra <= 1'b0;
            end else if (w_wrap) begin
                r_acc  <= w_acc_sum[FRAC_W-1:0];
                r_xtra <= w_acc_sum[FRAC_W];
            end
        end
    end
`else
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_end   = {1'b0, r_div};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_cnt    <= '0;
            r_div    <= DIV_W'(RESET_DIV);
            r_shadow <= DIV_W'(RESET_DIV);
        end else begin
            r_en     <= en;
            r_shadow <= w_shadow_nx;
            if (w_load) r_div <= w_shadow_nx;
            if (w_restart || w_wrap) begin
                r_cnt <= '0;
            end else if (w_adv) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign ce_p = w_adv & (r_cnt == '0);
    assign ce_n = w_adv & (r_div != '0) & (w_cnt_x == w_half);
    assign sq   = r_en & ((r_div == '0) | (w_cnt_x < w_half));

endmodule

// File: rtl/ce_divider_bank.sv
// ce_divider_bank: NUM_CH independent clock-enable generators with shared config port and sync.
// Define CE_FRAC_EN to build per-channel fractional period dithering; otherwise cfg_frac is ignored.
module ce_divider_bank
    import ce_pkg::*;
#(
    parameter  int unsigned NUM_CH    = CE_NUM_CH,
    parameter  int unsigned DIV_W     = CE_DIV_W,
    parameter  int unsigned RESET_DIV = CE_RESET_DIV,
    parameter  int unsigned FRAC_W    = CE_FRAC_W,
    localparam int unsigned CH_W      = ce_sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] hold,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic [NUM_CH-1:0] ce_p,
    output logic [NUM_CH-1:0] ce_n,
    output logic [NUM_CH-1:0] sq
);

    logic [NUM_CH-1:0] w_wr;

`ifndef CE_FRAC_EN
    logic w_unused_frac;
    assign w_unused_frac = ^cfg_frac;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            // Out-of-range channel selects match no channel and are dropped.
            assign w_wr[g] = cfg_we & (cfg_ch == CH_W'(g));

            ce_channel #(
`ifdef CE_FRAC_EN
                .FRAC_W    (FRAC_W),
`endif
                .DIV_W     (DIV_W),
                .RESET_DIV (RESET_DIV)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .en      (en[g]),
                .hold    (hold[g]),
                .sync    (sync),
                .wr      (w_wr[g]),
`ifdef CE_FRAC_EN
                .wr_frac (cfg_frac),
`endif
                .wr_div  (cfg_div),
                .ce_p    (ce_p[g]),
                .ce_n    (ce_n[g]),
                .sq      (sq[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ce_divider_bank.sv
// Self-checking bench for ce_divider_bank: period-level reference model plus directed timing checks.
// Honours CE_FRAC_EN so the same bench covers both builds.
module tb_ce_divider_bank;
    import ce_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int FW  = 8;
    localparam int RD  = 15;
`ifdef CE_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] hold = '0;
    logic           sync = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic [FW-1:0]  cfg_frac = '0;
    logic [NCH-1:0] ce_p, ce_n, sq;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference state: where each channel sits inside its current period.
    int m_run[NCH], m_pos[NCH], m_div[NCH], m_sh[NCH];
    int m_frac[NCH], m_fsh[NCH], m_acc[NCH], m_xtra[NCH];

    always #5 clk = ~clk;

    ce_divider_bank #(
        .NUM_CH    (NCH),
        .DIV_W     (DW),
        .RESET_DIV (RD),
        .FRAC_W    (FW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .hold     (hold),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_frac (cfg_frac),
        .ce_p     (ce_p),
        .ce_n     (ce_n),
        .sq       (sq)
    );

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_pos[c] = 0; m_div[c] = RD; m_sh[c] = RD;
            m_frac[c] = 0; m_fsh[c] = 0; m_acc[c] = 0; m_xtra[c] = 0;
        end
    endfunction

    function automatic void model_out(output logic [NCH-1:0] p, output logic [NCH-1:0] n,
                                      output logic [NCH-1:0] s);
        int  half;
        bit  act;
        for (int c = 0; c < NCH; c++) begin
            half = (m_div[c] + 1) / 2;
            act  = (m_run[c] != 0) && !hold[c];
            p[c] = act && (m_pos[c] == 0);
            n[c] = act && (m_div[c] != 0) && (m_pos[c] == half);
            s[c] = (m_run[c] != 0) && ((m_div[c] == 0) || (m_pos[c] < half));
        end
    endfunction

    function automatic void model_step();
        int sh_nx, fsh_nx, sum;
        bit wr;
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            wr     = cfg_we && (int'(cfg_ch) == c);
            sh_nx  = wr ? int'(cfg_div)  : m_sh[c];
            fsh_nx = wr ? int'(cfg_frac) : m_fsh[c];
            if (sync || m_run[c] == 0) begin
                m_pos[c] = 0; m_xtra[c] = 0; m_div[c] = sh_nx; m_frac[c] = fsh_nx;
            end else if (!hold[c]) begin
                if (m_pos[c] + 1 == m_div[c] + 1 + m_xtra[c]) begin
                    if (FRAC_ON) begin
                        sum       = m_acc[c] + m_frac[c];
                        m_xtra[c] = (sum >= (1 << FW)) ? 1 : 0;
                        m_acc[c]  = sum % (1 << FW);
                    end
                    m_pos[c] = 0; m_div[c] = sh_nx; m_frac[c] = fsh_nx;
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
            end
            m_sh[c] = sh_nx; m_fsh[c] = fsh_nx; m_run[c] = int'(en[c]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; en = '0; hold = '0; sync = 1'b0; cfg_we = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int dv, input int fr);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = DW'(dv); cfg_frac = FW'(fr);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] xp, xn, xs;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({ce_p, ce_n, sq} !== '0)
                $display("FAIL reset_hold cyc=%0d got p=%b n=%b sq=%b want 0", cyc, ce_p, ce_n, sq);
            if ({ce_p, ce_n, sq} !== '0) miscompares++;
            tick();
        end
        reset = 1'b0;
        en = '1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL reset_run cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            tick();
        end
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({ce_p, ce_n, sq} !== '0) begin
            miscompares++;
            $display("FAIL reset_async cyc=%0d got p=%b n=%b sq=%b want 0", cyc, ce_p, ce_n, sq);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            tick();
        end
    endtask

    task automatic test_default();
        logic [NCH-1:0] xp, xn, xs;
        int pq[$];
        int nq[$];
        apply_reset();
        en = 4'b0001;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL default cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            if (ce_p[0]) pq.push_back(cyc);
            if (ce_n[0]) nq.push_back(cyc);
            tick();
        end
        vectors++;
        if (pq.size() < 3 || nq.size() < 3) begin
            miscompares++;
            $display("FAIL default_count got ce_p=%0d ce_n=%0d want >=3 each", pq.size(), nq.size());
        end else begin
            for (int i = 1; i < pq.size(); i++) begin
                vectors++;
                if (pq[i] - pq[i-1] !== 16) begin
                    miscompares++;
                    $display("FAIL default_period got %0d want 16", pq[i] - pq[i-1]);
                end
            end
            for (int i = 0; i < nq.size() && i < pq.size(); i++) begin
                vectors++;
                if (nq[i] - pq[i] !== 8) begin
                    miscompares++;
                    $display("FAIL default_half got %0d want 8", nq[i] - pq[i]);
                end
            end
        end
    endtask

    task automatic test_cfg_midperiod();
        logic [NCH-1:0] xp, xn, xs;
        int pq[$];
        int exp_t;
        apply_reset();
        en = 4'b0011;
        for (int i = 0; i < 46; i++) begin
            cfg_we = (i == 5); cfg_ch = 2'd1; cfg_div = 8'd3;
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL cfg_mid cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            if (ce_p[1]) pq.push_back(cyc);
            tick();
        end
        cfg_we = 1'b0;
        vectors++;
        if (pq.size() < 6) begin
            miscompares++;
            $display("FAIL cfg_mid_count got %0d want >=6", pq.size());
        end else begin
            for (int i = 1; i < pq.size(); i++) begin
                exp_t = (i == 1) ? 16 : 4;
                vectors++;
                if (pq[i] - pq[i-1] !== exp_t) begin
                    miscompares++;
                    $display("FAIL cfg_mid_period idx=%0d got %0d want %0d", i, pq[i] - pq[i-1], exp_t);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [NCH-1:0] xp, xn, xs;
        int t_last, t_next;
        apply_reset();
        en = 4'b0001;
        t_last = -1;
        t_next = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL hold_pre cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            if (ce_p[0]) t_last = cyc;
            tick();
            if (m_pos[0] == 6 && t_last >= 0) break;
        end
        for (int i = 0; i < 36; i++) begin
            hold = (i < 5) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL hold cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            if (ce_p[0] && t_next < 0) t_next = cyc;
            tick();
        end
        hold = '0;
        vectors++;
        if (t_next - t_last !== 21) begin
            miscompares++;
            $display("FAIL hold_period got %0d want 21", t_next - t_last);
        end
    endtask

    task automatic test_sync();
        logic [NCH-1:0] xp, xn, xs;
        int cq[$];
        int t_sync;
        int nh, nr;
        apply_reset();
        write_cfg(1, 7, 0);
        en = 4'b0011;
        nh = int'($urandom_range(1, 5));
        nr = int'($urandom_range(3, 20));
        t_sync = -1;
        for (int i = 0; i < nh + nr + 50; i++) begin
            hold = (i >= 3 && i < 3 + nh) ? 4'b0010 : 4'b0000;
            sync = (i == 3 + nh + nr);
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL sync cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            if (sync) t_sync = cyc;
            if (t_sync >= 0 && cyc > t_sync && ce_p[1:0] == 2'b11) cq.push_back(cyc);
            tick();
        end
        sync = 1'b0;
        vectors++;
        if (cq.size() < 3 || cq[0] !== t_sync + 1) begin
            miscompares++;
            $display("FAIL sync_first got n=%0d first=%0d want n>=3 first=%0d",
                     cq.size(), (cq.size() > 0) ? cq[0] : -1, t_sync + 1);
        end else begin
            for (int i = 1; i < cq.size(); i++) begin
                vectors++;
                if (cq[i] - cq[i-1] !== 16) begin
                    miscompares++;
                    $display("FAIL sync_coincide got %0d want 16", cq[i] - cq[i-1]);
                end
            end
        end
    endtask

    task automatic test_frac();
        logic [NCH-1:0] xp, xn, xs;
        ce_cfg_t cfg;
        int pq[$];
        int want;
        apply_reset();
        cfg.div  = 8'd3;
        cfg.frac = 8'd128;
        write_cfg(2, int'(cfg.div), int'(cfg.frac));
        en = 4'b0100;
        for (int i = 0; i < 400 && pq.size() < 65; i++) begin
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL frac cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            if (ce_p[2]) pq.push_back(cyc);
            tick();
        end
        want = FRAC_ON ? 288 : 256;
        vectors++;
        if (pq.size() < 65) begin
            miscompares++;
            $display("FAIL frac_count got %0d want 65", pq.size());
        end else if (pq[64] - pq[0] !== want) begin
            miscompares++;
            $display("FAIL frac_span got %0d want %0d", pq[64] - pq[0], want);
        end
    endtask

    task automatic test_div0();
        logic [NCH-1:0] xp, xn, xs;
        apply_reset();
        write_cfg(3, 0, 0);
        en = 4'b1000;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs} || {ce_p[3], ce_n[3], sq[3]} !== 3'b101) begin
                miscompares++;
                $display("FAIL div0 cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            tick();
        end
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({ce_p, ce_n, sq} !== '0) begin
            miscompares++;
            $display("FAIL div0_reset got p=%b n=%b sq=%b want 0", ce_p, ce_n, sq);
        end
        tick();
        reset = 1'b0;
        en = '0;
    endtask

    task automatic test_random();
        logic [NCH-1:0] xp, xn, xs;
        apply_reset();
        en = 4'(int'($urandom));
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 31) == 0) en[c] = ~en[c];
                hold[c] = ($urandom_range(0, 7) == 0);
            end
            sync     = ($urandom_range(0, 63) == 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_div  = DW'($urandom_range(0, 12));
            cfg_frac = FW'($urandom);
            @(negedge clk);
            model_out(xp, xn, xs);
            vectors++;
            if ({ce_p, ce_n, sq} !== {xp, xn, xs}) begin
                miscompares++;
                $display("FAIL random cyc=%0d got p=%b n=%b sq=%b want p=%b n=%b sq=%b",
                         cyc, ce_p, ce_n, sq, xp, xn, xs);
            end
            tick();
        end
        hold = '0; sync = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        model_reset();
        test_reset();
        test_default();
        test_cfg_midperiod();
        test_hold();
        test_sync();
        test_frac();
        test_div0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
